float_rank_sorter: RTL and testbench
====================================

# float_rank_sorter

Top-level sort engine for IEEE-754-style floating-point words. After a start strobe, it accepts a burst of K words, one per clock. It computes each word's rank incrementally while the words are loading, then streams the words out in ascending numeric order, one per clock. It also exports the rank of every input slot as a packed vector for downstream permutation logic.

## Interface
Parameters:
- Nk, 23, mantissa width
- M, 8, exponent width
- L, Nk+M+1 (32), word width (sign | exponent | mantissa)
- K, 10, words per burst
- S, $clog2(K)+1 (5), rank field width (derived, not overridden)

Ports:
- clk  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high; one clock, reset is synchronous and active-high
- start  in  1  burst request, sampled only in IDLE
- inp_raw  in  L  input word, sampled during LOAD
- out  out  L  sorted output word (registered)
- ranger_out  out  S*K  rank of input slot i at bits [S*i +: S] (registered)

## Operation
- Sort key: word with sign=1 → key = ~word; sign=0 → key = word ^ (1<<(L-1)).
  - Keys are compared as L-bit unsigned values, giving total numeric order.
  - -0 sorts before +0. NaNs are ordered by bit pattern.
- Ties are stable: the lower input index ranks first.
- Final rank of i = #{j: key_j < key_i} + #{j<i: key_j == key_i}. Ranks span 0..K-1 and are a permutation.
- States:
  - IDLE: waits for start.
  - LOAD: K cycles, input index n = 0..K-1.
  - OUT: K cycles, t = 0..K-1.
  - Return to IDLE after OUT.
- LOAD, at each edge:
  - Store inp_raw in slot n.
  - rank_n = #{stored j<n: key_j <= key_n}.
  - Every stored j with key_j > key_n gets rank_j + 1.
  - Comparison is parallel against all stored slots (K comparators).
- OUT: out = the stored word whose rank equals t.
- start asserted while in LOAD or OUT is ignored. A held start re-triggers only from IDLE.
- On accepting start, all ranks and the slot count are cleared.

## Timing
- Reset: state=IDLE, out=0, ranger_out=0, storage cleared. Reset overrides everything, including mid-LOAD or mid-OUT, which aborts the burst.
- Call E0 the edge that samples start=1 in IDLE.
- Edges E1..EK sample inp_raw words 0..K-1, with no gaps.
- ranger_out updates after each LOAD edge (partial ranks).
  - After EK it holds the final permutation.
  - It then holds until the next accepted start or reset.
- After edge E(K+1+t), out = rank-t word, for t=0..K-1.
  - Latency from the last input to the first sorted word is 1 cycle.
- After E(2K+1), the state is IDLE and out returns to 0.
  - start may be sampled at E(2K+1) itself (back-to-back bursts).
- No input-valid qualifier: every LOAD cycle consumes a word.

## Configuration
- SORT_DESCENDING_EN:
  - When defined, the comparison is inverted: largest key gets rank 0, and out streams in descending order.
  - Ties keep the lower input index first.
- When undefined: ascending order as specified above.

## Test plan
- Reset then idle: reset 1 cycle, start=0 for 5 cycles → out=0 and ranger_out=0 throughout.
- Main burst, start pulse then words 40D00000, 03266666, C1A81687, C1A00000, F0000000, 41900000, 41400000, BF800000, 41500FF0, C1200000:
  - ranger_out slots 0..9 = 6, 5, 1, 2, 0, 9, 7, 4, 8, 3.
  - out sequence: F0000000, C1A81687, C1A00000, C1200000, BF800000, 03266666, 40D00000, 41400000, 41500FF0, 41900000.
  - After the sequence, out returns to 0.
- Reset mid-LOAD: start, 2 words loaded, then reset → out=0, ranger_out=0, IDLE.
  - A new full burst afterwards sorts correctly with no residue from the aborted burst.
- Ties and signed zero: burst of 00000000, 80000000, 3F800000 repeated over the K slots → equal words keep input order; 80000000 precedes 00000000.
- start held high through LOAD and OUT → no re-trigger until IDLE, then a second burst begins at E(2K+1).
- With SORT_DESCENDING_EN, main burst → out begins 41900000 and ends F0000000; ranger_out slot 5 = 0.

Source files
------------

// File: rtl/float_rank_sorter_if.sv
// Bus bundle for float_rank_sorter: burst request, input word stream,
// sorted output word and the packed per-slot rank vector.
interface float_rank_sorter_if #(
  parameter int unsigned L = 32,
  parameter int unsigned K = 10
);
  localparam int unsigned S = $clog2(K) + 1;

  logic           start;
  logic [L-1:0]   inp_raw;
  logic [L-1:0]   out;
  logic [S*K-1:0] ranger_out;

  modport master (
    output start,
    output inp_raw,
    input  out,
    input  ranger_out
  );

  modport slave (
    input  start,
    input  inp_raw,
    output out,
    output ranger_out
  );
endinterface

// File: rtl/float_rank_sorter.sv
// float_rank_sorter: loads a burst of K floating-point words, ranks them
// incrementally while loading, then streams them out in numeric order.
// Optional build macro SORT_DESCENDING_EN: largest key ranks first and the
// output streams in descending order (ties still keep lower input index first).
module float_rank_sorter #(
  parameter int unsigned Nk = 23,
  parameter int unsigned M  = 8,
  parameter int unsigned L  = Nk + M + 1,
  parameter int unsigned K  = 10
) (
  input logic               clk,
  input logic               reset,
  float_rank_sorter_if.slave bus
);
  localparam int unsigned S = $clog2(K) + 1;

  typedef enum logic [1:0] {StIdle, StLoad, StOut} state_e;

  state_e         state_q, state_d;
  logic [S-1:0]   cnt_q, cnt_d;
  logic [L-1:0]   words_q [K];
  logic [S-1:0]   ranks_q [K];
  logic [L-1:0]   out_q;

  logic [L-1:0]   new_key;
  logic [L-1:0]   slot_key [K];
  logic [K-1:0]   ahead;   // stored slot orders before the incoming word
  logic [K-1:0]   bump;    // stored slot is pushed one place back
  logic [S-1:0]   new_rank;
  logic [L-1:0]   sel_word;
  logic [S*K-1:0] ranger;
  logic           last_cnt;

  // Map a float word to an unsigned key whose order is the numeric order;
  // negatives are fully inverted so -0 lands just below +0.
  function automatic logic [L-1:0] sort_key(input logic [L-1:0] w);
    return w[L-1] ? ~w : {1'b1, w[L-2:0]};
  endfunction

  assign last_cnt = (cnt_q == S'(K - 1));

  // FSM next-state and slot/cycle counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          state_d = StLoad;
          cnt_d   = '0;
        end
      end
      StLoad: begin
        cnt_d = cnt_q + S'(1);
        if (last_cnt) begin
          state_d = StOut;
          cnt_d   = '0;
        end
      end
      StOut: begin
        cnt_d = cnt_q + S'(1);
        if (last_cnt) begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  // Parallel compare of the incoming word against every loaded slot
  always_comb begin
    new_key  = sort_key(bus.inp_raw);
    new_rank = '0;
    ahead    = '0;
    bump     = '0;
    for (int j = 0; j < K; j++) begin
      slot_key[j] = sort_key(words_q[j]);
`ifdef SORT_DESCENDING_EN
      ahead[j] = (S'(j) < cnt_q) && (slot_key[j] >= new_key);
      bump[j]  = (S'(j) < cnt_q) && (slot_key[j] <  new_key);
`else
      ahead[j] = (S'(j) < cnt_q) && (slot_key[j] <= new_key);
      bump[j]  = (S'(j) < cnt_q) && (slot_key[j] >  new_key);
`endif
      if (ahead[j]) begin
        new_rank = new_rank + S'(1);
      end
    end
  end

  // Output mux: pick the slot whose rank equals the output cycle index
  always_comb begin
    sel_word = '0;
    ranger   = '0;
    for (int j = 0; j < K; j++) begin
      if (ranks_q[j] == cnt_q) begin
        sel_word = words_q[j];
      end
      ranger[S*j +: S] = ranks_q[j];
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Datapath: slot storage, rank update and registered output word
  always_ff @(posedge clk) begin
    if (reset) begin
      out_q <= '0;
      for (int j = 0; j < K; j++) begin
        words_q[j] <= '0;
        ranks_q[j] <= '0;
      end
    end else begin
      case (state_q)
        StIdle: begin
          out_q <= '0;
          if (bus.start) begin
            for (int j = 0; j < K; j++) begin
              ranks_q[j] <= '0;
            end
          end
        end
        StLoad: begin
          for (int j = 0; j < K; j++) begin
            if (S'(j) == cnt_q) begin
              words_q[j] <= bus.inp_raw;
              ranks_q[j] <= new_rank;
            end else if (bump[j]) begin
              ranks_q[j] <= ranks_q[j] + S'(1);
            end
          end
        end
        StOut: begin
          out_q <= sel_word;
        end
        default: begin
          out_q <= '0;
        end
      endcase
    end
  end

  assign bus.out        = out_q;
  assign bus.ranger_out = ranger;

endmodule

// File: tb/tb_float_rank_sorter.sv
// Bench for float_rank_sorter: randomized bursts checked every cycle against
// a rank-by-formula model, plus literal expectations for the reference burst.
module tb_float_rank_sorter;
  localparam int unsigned K  = 10;
  localparam int unsigned L  = 32;
  localparam int unsigned S  = $clog2(K) + 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  float_rank_sorter_if #(.L(L), .K(K)) bus ();

  float_rank_sorter #(.Nk(23), .M(8), .L(L), .K(K)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  // Model state
  int          m_phase = 0;   // 0 idle, 1 load, 2 out
  int          m_cnt = 0;
  logic [31:0] m_words [K];
  logic [31:0] m_sorted [K];
  int          m_rng [K];
  logic [31:0] m_out = '0;

  logic [31:0] bw [K];

  function automatic logic [31:0] fkey(input logic [31:0] w);
    return w[31] ? ~w : (w ^ 32'h8000_0000);
  endfunction

  // Rank of word i among the first n loaded words, straight from the ordering rule
  function automatic int rank_of(input int i, input int n);
    int r = 0;
    for (int j = 0; j < n; j++) begin
`ifdef SORT_DESCENDING_EN
      if (fkey(m_words[j]) > fkey(m_words[i])) r++;
`else
      if (fkey(m_words[j]) < fkey(m_words[i])) r++;
`endif
      else if (j < i && fkey(m_words[j]) == fkey(m_words[i])) r++;
    end
    return r;
  endfunction

  function automatic logic [S*K-1:0] m_rng_vec();
    logic [S*K-1:0] v = '0;
    for (int j = 0; j < K; j++) v[S*j +: S] = S'(m_rng[j]);
    return v;
  endfunction

  task automatic model_edge(input bit rst, input bit st, input logic [31:0] w);
    if (rst) begin
      m_phase = 0; m_cnt = 0; m_out = '0;
      for (int j = 0; j < K; j++) begin m_rng[j] = 0; m_words[j] = '0; end
    end else if (m_phase == 0) begin
      m_out = '0;
      if (st) begin
        m_phase = 1; m_cnt = 0;
        for (int j = 0; j < K; j++) m_rng[j] = 0;
      end
    end else if (m_phase == 1) begin
      m_words[m_cnt] = w;
      m_cnt++;
      for (int i = 0; i < m_cnt; i++) m_rng[i] = rank_of(i, m_cnt);
      if (m_cnt == K) begin
        for (int i = 0; i < K; i++) m_sorted[m_rng[i]] = m_words[i];
        m_phase = 2; m_cnt = 0;
      end
    end else begin
      m_out = m_sorted[m_cnt];
      m_cnt++;
      if (m_cnt == K) begin m_phase = 0; m_cnt = 0; end
    end
  endtask

  // One clock: drive inputs, advance the model at the edge, settle just after
  task automatic cyc(input bit rst, input bit st, input logic [31:0] w);
    reset = rst; bus.start = st; bus.inp_raw = w;
    @(posedge clk);
    model_edge(rst, st, w);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, act, req);
    end
  endtask

  // Continuous compare against the model, away from the active edge
  always @(negedge clk) begin
    if (chk_en) begin
      check("out_vs_model", 64'(bus.out), 64'(m_out));
      check("ranger_vs_model", 64'(bus.ranger_out), 64'(m_rng_vec()));
    end
  end

  task automatic run_burst(input bit st_level);
    cyc(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < K; i++) cyc(1'b0, st_level, bw[i]);
    for (int t = 0; t < K; t++) cyc(1'b0, st_level, $urandom);
  endtask

  logic [31:0] main_w [K] = '{32'h40D00000, 32'h03266666, 32'hC1A81687, 32'hC1A00000,
                              32'hF0000000, 32'h41900000, 32'h41400000, 32'hBF800000,
                              32'h41500FF0, 32'hC1200000};
  logic [31:0] main_seq [K] = '{32'hF0000000, 32'hC1A81687, 32'hC1A00000, 32'hC1200000,
                                32'hBF800000, 32'h03266666, 32'h40D00000, 32'h41400000,
                                32'h41500FF0, 32'h41900000};
  int main_rank [K] = '{6, 5, 1, 2, 0, 9, 7, 4, 8, 3};
  logic [31:0] pool [6] = '{32'h00000000, 32'h80000000, 32'h7FC00000, 32'hFF800000,
                            32'h3F800000, 32'hBF800000};

  initial begin
    logic [S*K-1:0] lit_rng;
    bus.start = 1'b0;
    bus.inp_raw = '0;

    // Reset then idle
    cyc(1'b1, 1'b0, 32'h0);
    chk_en = 1'b1;
    for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, $urandom);
    check("idle_out", 64'(bus.out), 64'h0);
    check("idle_ranger", 64'(bus.ranger_out), 64'h0);

    // Reference burst with literal expectations
    for (int i = 0; i < K; i++) bw[i] = main_w[i];
    cyc(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < K; i++) cyc(1'b0, 1'b0, bw[i]);
    lit_rng = '0;
    for (int j = 0; j < K; j++) begin
`ifdef SORT_DESCENDING_EN
      lit_rng[S*j +: S] = S'(K - 1 - main_rank[j]);
`else
      lit_rng[S*j +: S] = S'(main_rank[j]);
`endif
    end
    check("main_ranger_lit", 64'(bus.ranger_out), 64'(lit_rng));
    check("model_ranger_lit", 64'(m_rng_vec()), 64'(lit_rng));
`ifdef SORT_DESCENDING_EN
    check("main_slot5_rank", 64'(bus.ranger_out[S*5 +: S]), 64'h0);
`endif
    for (int t = 0; t < K; t++) begin
      cyc(1'b0, 1'b0, $urandom);
`ifdef SORT_DESCENDING_EN
      check("main_out_lit", 64'(bus.out), 64'(main_seq[K-1-t]));
`else
      check("main_out_lit", 64'(bus.out), 64'(main_seq[t]));
`endif
    end
    cyc(1'b0, 1'b0, 32'h0);
    check("main_out_returns_0", 64'(bus.out), 64'h0);

    // Reset mid-LOAD, then a clean burst
    cyc(1'b0, 1'b1, 32'h0);
    cyc(1'b0, 1'b0, 32'h12345678);
    cyc(1'b0, 1'b0, 32'h87654321);
    cyc(1'b1, 1'b0, 32'h0);
    check("abort_out", 64'(bus.out), 64'h0);
    check("abort_ranger", 64'(bus.ranger_out), 64'h0);
    cyc(1'b0, 1'b0, 32'hDEADBEEF);
    check("abort_stays_idle", 64'(bus.ranger_out), 64'h0);
    for (int i = 0; i < K; i++) bw[i] = $urandom;
    run_burst(1'b0);

    // Ties and signed zero
    for (int i = 0; i < K; i++) bw[i] = (i % 3 == 0) ? 32'h0 : (i % 3 == 1) ? 32'h80000000
                                                                         : 32'h3F800000;
    cyc(1'b0, 1'b1, 32'h0);
    for (int i = 0; i < K; i++) cyc(1'b0, 1'b0, bw[i]);
    check("tie_slot0_rank", 64'(bus.ranger_out[0 +: S]), 64'd3);
`ifdef SORT_DESCENDING_EN
    check("tie_slot1_rank", 64'(bus.ranger_out[S +: S]), 64'd7);
`else
    check("tie_slot1_rank", 64'(bus.ranger_out[S +: S]), 64'd0);
`endif
    for (int t = 0; t < K; t++) cyc(1'b0, 1'b0, $urandom);

    // start held high through a whole burst re-triggers at E(2K+1)
    for (int i = 0; i < K; i++) bw[i] = $urandom;
    run_burst(1'b1);
    cyc(1'b0, 1'b1, 32'h0);
    check("held_retrigger_out", 64'(bus.out), 64'h0);
    check("held_retrigger_ranger", 64'(bus.ranger_out), 64'h0);
    for (int i = 0; i < K; i++) begin
      bw[i] = $urandom;
      cyc(1'b0, 1'b1, bw[i]);
    end
    for (int t = 0; t < K; t++) cyc(1'b0, 1'b1, $urandom);
    cyc(1'b0, 1'b0, 32'h0);

    // Randomized bursts with tie-heavy pools and random idle gaps
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < K; i++)
        bw[i] = ($urandom_range(0, 2) == 0) ? $urandom : pool[$urandom_range(0, 5)];
      run_burst($urandom_range(0, 1) == 1);
      for (int g = 0; g < int'($urandom_range(0, 2)); g++) cyc(1'b0, 1'b0, $urandom);
    end

    cyc(1'b0, 1'b0, 32'h0);
    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
